// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one bram_wrapper port among REQUESTERS clients.
// One whole-word read or write per grant; the wrapper sees a single-cycle enable pulse.
module bram_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int ADDR_SIZE  = 10,
  parameter int WIDTH      = 2048,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [REQUESTERS-1:0]           req_in,
  input  logic [REQUESTERS-1:0]           we_in,
  input  logic [REQUESTERS*ADDR_SIZE-1:0] addr_in,
  input  logic [REQUESTERS*WIDTH-1:0]     wdata_in,
  output logic [REQUESTERS-1:0]           grant_out,
  output logic [REQUESTERS-1:0]           done_out,
  output logic [WIDTH-1:0]                rdata_out,
  output logic                            error_out,
  output logic                            busy_out,
  output logic [ADDR_SIZE-1:0]            mem_addr_out,
  output logic [WIDTH-1:0]                mem_data_out,
  output logic                            mem_we_out,
  output logic                            mem_re_out,
  input  logic [WIDTH-1:0]                mem_data_in,
  input  logic                            mem_finished_in
);

  localparam int IDX_W     = $clog2(REQUESTERS);
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(REQUESTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic [REQUESTERS-1:0]  done_q, done_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;

  // First requester after the previous winner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!pick_vld && req_in[i] && (i == (int'(last_q) + k) % REQUESTERS)) begin
          pick_vld = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = '0;
    rdata_d = rdata_q;
    error_d = error_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          last_d  = pick_idx;
          state_d = S_ISSUE;
          for (int i = 0; i < REQUESTERS; i++) begin
            grant_d[i] = (int'(pick_idx) == i);
            if (int'(pick_idx) == i) begin
              we_d    = we_in[i];
              addr_d  = addr_in[i*ADDR_SIZE +: ADDR_SIZE];
              wdata_d = wdata_in[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle as the timeout still counts as success.
        if (mem_finished_in) begin
          if (!we_q) rdata_d = mem_data_in;
          done_d  = grant_q;
          state_d = S_RELEASE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          error_d = 1'b1;
          done_d  = grant_q;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out   = (state_q != S_IDLE);
    mem_we_out = (state_q == S_ISSUE) && we_q;
    mem_re_out = (state_q == S_ISSUE) && !we_q;
  end

  assign grant_out    = grant_q;
  assign done_out     = done_q;
  assign rdata_out    = rdata_q;
  assign error_out    = error_q;
  assign mem_addr_out = addr_q;
  assign mem_data_out = wdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed timing scenarios followed by a
// randomized phase scored against a transaction-level model with a memory-backed wrapper.
module tb_bram_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, we, wd_req;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_fin, wd_fin;

  logic [N-1:0]  grant, done;
  logic [DW-1:0] rdata, mdata;
  logic          err, busy, mwe, mre;
  logic [AW-1:0] maddr;

  logic [N-1:0]  wd_grant, wd_done;
  logic [DW-1:0] wd_rdata, wd_mdata;
  logic          wd_err, wd_busy, wd_mwe, wd_mre;
  logic [AW-1:0] wd_maddr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.REQUESTERS(N), .ADDR_SIZE(AW), .WIDTH(DW), .TIMEOUT(4096)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .we_in(we), .addr_in(addr),
    .wdata_in(wdata), .grant_out(grant), .done_out(done), .rdata_out(rdata),
    .error_out(err), .busy_out(busy), .mem_addr_out(maddr), .mem_data_out(mdata),
    .mem_we_out(mwe), .mem_re_out(mre), .mem_data_in(mem_rdata),
    .mem_finished_in(mem_fin)
  );

  bram_arbiter #(.REQUESTERS(N), .ADDR_SIZE(AW), .WIDTH(DW), .TIMEOUT(16)) dut_wd (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(wd_req), .we_in(we), .addr_in(addr),
    .wdata_in(wdata), .grant_out(wd_grant), .done_out(wd_done), .rdata_out(wd_rdata),
    .error_out(wd_err), .busy_out(wd_busy), .mem_addr_out(wd_maddr),
    .mem_data_out(wd_mdata), .mem_we_out(wd_mwe), .mem_re_out(wd_mre),
    .mem_data_in(mem_rdata), .mem_finished_in(wd_fin)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_cli(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int k = 0; k < N; k++) begin
      if (k == i) begin
        we[k]             = w;
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
      end
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  // Winner = first requester found scanning last+1, last+2, ... modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(r, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  int            w, lat, waited, last_m, exp_done, exp_owner, op_owner, op_cnt;
  bit            bsy_m, prev_idle, op_act, op_we, issued;
  logic [N-1:0]  prev_req, dropped;
  logic [3:0]    op_addr;
  logic [DW-1:0] op_data, rd_m, exp_rd;
  logic [DW-1:0] mem_m [16];
  bit            cli_we   [N];
  logic [AW-1:0] cli_addr [N];
  logic [DW-1:0] cli_data [N];

  initial begin
    #1_000_000;
    $display("FAIL global time limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; req = '0; wd_req = '0; we = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_fin = 1'b0; wd_fin = 1'b0;

    // ---- reset state
    do_reset();
    chk("rst grant", 64'(grant), 0);
    chk("rst done",  64'(done), 0);
    chk("rst rdata", rdata, 0);
    chk("rst error", 64'(err), 0);
    chk("rst busy",  64'(busy), 0);
    chk("rst maddr", 64'(maddr), 0);
    chk("rst mdata", mdata, 0);
    chk("rst en",    64'({mwe, mre}), 0);

    // ---- single read, finished in cycle 40
    set_cli(0, 1'b0, 10'd5, 64'h0);
    req = 2'b01;
    step();
    chk("rd grant", 64'(grant), 64'h1);
    chk("rd re c1", 64'(mre), 1);
    chk("rd we c1", 64'(mwe), 0);
    chk("rd addr",  64'(maddr), 5);
    chk("rd busy c1", 64'(busy), 1);
    for (int c = 2; c <= 40; c++) begin
      step();
      chk("rd re wait", 64'(mre), 0);
      chk("rd done wait", 64'(done), 0);
      chk("rd busy wait", 64'(busy), 1);
    end
    mem_rdata = {8{8'hA5}};
    mem_fin = 1'b1;
    step();
    mem_fin = 1'b0;
    chk("rd done c41", 64'(done), 64'h1);
    chk("rd rdata", rdata, {8{8'hA5}});
    chk("rd busy c41", 64'(busy), 1);
    req = 2'b00;
    step();
    chk("rd busy c42", 64'(busy), 0);
    chk("rd done c42", 64'(done), 0);
    chk("rd grant c42", 64'(grant), 0);

    // ---- single write from client 1
    set_cli(1, 1'b1, 10'd7, 64'h1234);
    req = 2'b10;
    step();
    chk("wr grant", 64'(grant), 64'h2);
    chk("wr we c1", 64'(mwe), 1);
    chk("wr re c1", 64'(mre), 0);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("wr we wait", 64'(mwe), 0);
      chk("wr addr hold", 64'(maddr), 7);
      chk("wr data hold", mdata, 64'h1234);
    end
    mem_rdata = 64'hFFFF_0000_FFFF_0000;
    mem_fin = 1'b1;
    step();
    mem_fin = 1'b0;
    chk("wr done", 64'(done), 64'h2);
    chk("wr rdata kept", rdata, {8{8'hA5}});
    req = 2'b00;
    step();
    chk("wr done clr", 64'(done), 0);

    // ---- fields latched at grant
    set_cli(0, 1'b0, 10'd3, 64'h0);
    req = 2'b01;
    step();
    chk("lat grant", 64'(grant), 64'h1);
    chk("lat addr c1", 64'(maddr), 3);
    step();
    set_cli(0, 1'b1, 10'd9, 64'h55);
    chk("lat addr c2", 64'(maddr), 3);
    for (int c = 3; c <= 6; c++) begin
      step();
      chk("lat addr wait", 64'(maddr), 3);
      chk("lat no we", 64'(mwe), 0);
    end
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    mem_fin = 1'b1;
    step();
    mem_fin = 1'b0;
    chk("lat done", 64'(done), 64'h1);
    chk("lat rdata", rdata, 64'h0123_4567_89AB_CDEF);
    chk("lat addr rel", 64'(maddr), 3);
    req = 2'b00;
    step();

    // ---- contention from reset
    do_reset();
    set_cli(0, 1'b0, 10'd1, 64'h0);
    set_cli(1, 1'b0, 10'd2, 64'h0);
    req = 2'b11;
    last_m = N - 1;
    for (int t = 0; t < 4; t++) begin
      w = rr_pick(req, last_m);
      waited = 0;
      while (grant == '0 && waited < 10) begin
        step();
        waited++;
      end
      chk("cont grant", 64'(grant), 64'(1) << w);
      last_m = w;
      step();
      lat = $urandom_range(0, 4);
      repeat (lat) step();
      mem_rdata = {$urandom, $urandom};
      exp_rd = mem_rdata;
      mem_fin = 1'b1;
      step();
      mem_fin = 1'b0;
      chk("cont done", 64'(done), 64'(1) << w);
      chk("cont rdata", rdata, exp_rd);
      step();
    end
    req = 2'b00;
    step();

    // ---- watchdog (TIMEOUT=16 instance, finished never asserted)
    do_reset();
    chk("wd rst rdata", wd_rdata, 0);
    chk("wd rst busy", 64'(wd_busy), 0);
    chk("wd rst maddr", 64'(wd_maddr), 0);
    chk("wd rst mdata", wd_mdata, 0);
    set_cli(0, 1'b0, 10'd11, 64'h0);
    wd_req = 2'b01;
    step();
    chk("wd grant", 64'(wd_grant), 64'h1);
    chk("wd en c1", 64'({wd_mwe, wd_mre}), 64'h1);
    for (int c = 2; c <= 17; c++) begin
      step();
      chk("wd err early", 64'(wd_err), 0);
      chk("wd done early", 64'(wd_done), 0);
    end
    step();
    chk("wd err c18", 64'(wd_err), 1);
    chk("wd done c18", 64'(wd_done), 64'h1);
    wd_req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("wd err sticky", 64'(wd_err), 1);
      chk("wd done after", 64'(wd_done), 0);
    end

    // ---- reset during WAIT
    do_reset();
    set_cli(0, 1'b1, 10'd4, 64'hDEAD);
    req = 2'b01;
    step();
    step();
    step();
    rst_n = 1'b0;
    req = 2'b00;
    step();
    rst_n = 1'b1;
    chk("mrst grant", 64'(grant), 0);
    chk("mrst done", 64'(done), 0);
    chk("mrst busy", 64'(busy), 0);
    chk("mrst maddr", 64'(maddr), 0);
    chk("mrst mdata", mdata, 0);
    chk("mrst en", 64'({mwe, mre}), 0);
    chk("mrst err", 64'(err), 0);
    step();
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    mem_fin = 1'b1;
    step();
    mem_fin = 1'b0;
    chk("stale done", 64'(done), 0);
    chk("stale busy", 64'(busy), 0);
    step();
    chk("stale done2", 64'(done), 0);
    chk("stale rdata", rdata, 0);

    // ---- randomized traffic against the transaction model
    do_reset();
    for (int a = 0; a < 16; a++) mem_m[a] = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      cli_we[i] = 1'b0; cli_addr[i] = '0; cli_data[i] = '0;
    end
    req = '0; last_m = N - 1; bsy_m = 1'b0; prev_idle = 1'b1; prev_req = '0;
    op_act = 1'b0; exp_done = -10; exp_owner = 0; rd_m = '0;
    for (int it = 0; it < 400; it++) begin
      step();
      issued = 1'b0;
      dropped = '0;
      if (cyc == exp_done + 1) bsy_m = 1'b0;
      if (prev_idle && prev_req != '0) begin
        w = rr_pick(prev_req, last_m);
        last_m = w;
        chk("rnd grant", 64'(grant), 64'(1) << w);
        chk("rnd we pulse", 64'(mwe), 64'(cli_we[w]));
        chk("rnd re pulse", 64'(mre), 64'(!cli_we[w]));
        chk("rnd addr", 64'(maddr), 64'(cli_addr[w]));
        if (cli_we[w]) chk("rnd wdata", mdata, cli_data[w]);
        op_act = 1'b1; op_we = cli_we[w]; op_addr = cli_addr[w][3:0];
        op_data = cli_data[w]; op_owner = w; op_cnt = $urandom_range(1, 6);
        issued = 1'b1;
        bsy_m = 1'b1;
      end else begin
        chk("rnd no enable", 64'({mwe, mre}), 0);
        if (prev_idle) chk("rnd idle grant", 64'(grant), 0);
      end
      chk("rnd busy", 64'(busy), 64'(bsy_m));
      if (cyc == exp_done) begin
        chk("rnd done", 64'(done), 64'(1) << exp_owner);
        chk("rnd rdata", rdata, rd_m);
        req &= ~(N'(1) << exp_owner);
        dropped |= N'(1) << exp_owner;
      end else begin
        chk("rnd done idle", 64'(done), 0);
      end
      mem_fin = 1'b0;
      if (op_act && !issued) begin
        op_cnt--;
        if (op_cnt == 0) begin
          mem_fin = 1'b1;
          if (op_we) begin
            mem_m[op_addr] = op_data;
            mem_rdata = {$urandom, $urandom};
          end else begin
            mem_rdata = mem_m[op_addr];
            rd_m = mem_m[op_addr];
          end
          exp_done = cyc + 1;
          exp_owner = op_owner;
          op_act = 1'b0;
        end
      end else if (!op_act && $urandom_range(0, 3) == 0) begin
        mem_fin = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end
      for (int i = 0; i < N; i++) begin
        if (!bit_of(req, i) && !bit_of(dropped, i) && $urandom_range(0, 3) == 0) begin
          cli_we[i]   = 1'($urandom_range(0, 1));
          cli_addr[i] = AW'($urandom_range(0, 15));
          cli_data[i] = {$urandom, $urandom};
          set_cli(i, cli_we[i], cli_addr[i], cli_data[i]);
          req |= N'(1) << i;
        end
      end
      prev_idle = !bsy_m;
      prev_req = req;
    end
    req = '0;
    mem_fin = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
